// File: rtl/sm_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module      : sm_muldiv_if
//  Description : Issue/result bundle between control unit and sm_muldiv.
//  Revision    : 1.0
// ============================================================================
interface sm_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output start, op, srcA, srcB, cancel,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, op, srcA, srcB, cancel,
        output busy, done, hi, lo, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/sm_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : sm_muldiv
//  Description : Radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO regs.
//  Revision    : 1.0
// ============================================================================
module sm_muldiv #(
    parameter int WIDTH = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    sm_muldiv_if.slave   mdu_if
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] phi_q, phi_d;
    logic [WIDTH-1:0] plo_q, plo_d;
    logic [WIDTH-1:0] srca_q, srca_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             w_sa, w_sb;
    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0] w_quo_fix, w_rem_fix;

    assign w_sa    = mdu_if.op[0] & mdu_if.srcA[WIDTH-1];
    assign w_sb    = mdu_if.op[0] & mdu_if.srcB[WIDTH-1];
    assign w_abs_a = w_sa ? -mdu_if.srcA : mdu_if.srcA;
    assign w_abs_b = w_sb ? -mdu_if.srcB : mdu_if.srcB;

    // Multiply: {phi,plo} shifts right; plo starts as the multiplier.
    assign w_mul_sum = {1'b0, phi_q} + (plo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});

    // Divide: phi is the partial remainder, plo shifts dividend out and quotient in.
    assign w_div_shift = {phi_q, plo_q[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, m_q};

    assign w_prod     = {phi_q, plo_q};
    assign w_prod_fix = (sa_q ^ sb_q) ? -w_prod : w_prod;
    assign w_quo_fix  = (sa_q ^ sb_q) ? -plo_q : plo_q;
    assign w_rem_fix  = sa_q ? -phi_q : phi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            m_q     <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            srca_q  <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            m_q     <= m_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            srca_q  <= srca_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bzero_q <= bzero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        m_d     = m_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        srca_d  = srca_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mdu_if.start) begin
                    state_d = S_CALC;
                    op_d    = mdu_if.op;
                    sa_d    = w_sa;
                    sb_d    = w_sb;
                    srca_d  = mdu_if.srcA;
                    bzero_d = (mdu_if.srcB == '0);
                    cnt_d   = CW'(WIDTH);
                    phi_d   = '0;
                    if (mdu_if.op[1]) begin
                        m_d   = w_abs_b;
                        plo_d = w_abs_a;
                    end else begin
                        m_d   = w_abs_a;
                        plo_d = w_abs_b;
                    end
                end
            end
            S_CALC: begin
                if (mdu_if.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (op_q[1]) begin
                        if (!w_div_diff[WIDTH]) begin
                            phi_d = w_div_diff[WIDTH-1:0];
                            plo_d = {plo_q[WIDTH-2:0], 1'b1};
                        end else begin
                            phi_d = w_div_shift[WIDTH-1:0];
                            plo_d = {plo_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        phi_d = w_mul_sum[WIDTH:1];
                        plo_d = {w_mul_sum[0], plo_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!mdu_if.cancel) begin
                    done_d = 1'b1;
                    if (!op_q[1]) begin
                        hi_d  = w_prod_fix[2*WIDTH-1:WIDTH];
                        lo_d  = w_prod_fix[WIDTH-1:0];
                        dbz_d = 1'b0;
                    end else if (bzero_q) begin
                        hi_d  = srca_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        // MIN / -1 wraps naturally to MIN with a zero remainder.
                        hi_d  = w_rem_fix;
                        lo_d  = w_quo_fix;
                        dbz_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign mdu_if.busy        = busy_q;
    assign mdu_if.done        = done_q;
    assign mdu_if.hi          = hi_q;
    assign mdu_if.lo          = lo_q;
    assign mdu_if.div_by_zero = dbz_q;
endmodule
`default_nettype wire

// File: tb/tb_sm_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm_muldiv
//  Description : Directed vector bench for sm_muldiv at WIDTH = 32.
//  Revision    : 1.0
// ============================================================================
module tb_sm_muldiv;
    localparam int W = 32;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sm_muldiv_if #(.WIDTH(W)) bus ();

    sm_muldiv #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .mdu_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Returns at the negedge of cycle 1 of the issued operation.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.srcA  = a;
        bus.srcB  = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int k0, output int cyc, output bit busy_ok);
        cyc     = -1;
        busy_ok = 1'b1;
        for (int k = k0; k <= 60; k++) begin
            if (bus.done) begin
                cyc = k;
                if (bus.busy) busy_ok = 1'b0;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    vec_t vecs [14];

    initial begin
        int  cyc;
        bit  bok;
        bit  seen;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[7]  = '{2'b10, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{2'b00, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        vecs[9]  = '{2'b11, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
        vecs[10] = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[12] = '{2'b10, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 1'b0};
        vecs[13] = '{2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        bus.op     = 2'b00;
        bus.srcA   = '0;
        bus.srcB   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi",   64'(bus.hi),   64'd0);
        check("reset_lo",   64'(bus.lo),   64'd0);
        check("reset_dbz",  64'(bus.div_by_zero), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(1, cyc, bok);
            check($sformatf("v%0d_latency", i), 64'(cyc), 64'd34);
            check($sformatf("v%0d_busy", i), 64'(bok), 64'd1);
            check($sformatf("v%0d_hi", i), 64'(bus.hi), 64'(vecs[i].hi));
            check($sformatf("v%0d_lo", i), 64'(bus.lo), 64'(vecs[i].lo));
            check($sformatf("v%0d_dbz", i), 64'(bus.div_by_zero), 64'(vecs[i].dbz));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
        end

        // Second start in cycle 10 must be ignored.
        issue(2'b00, 32'h00001234, 32'h00000100);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.srcA  = 32'd9;
        bus.srcB  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(11, cyc, bok);
        check("ign_latency", 64'(cyc), 64'd34);
        check("ign_busy", 64'(bok), 64'd1);
        check("ign_hi", 64'(bus.hi), 64'd0);
        check("ign_lo", 64'(bus.lo), 64'h00123400);

        // Cancel in cycle 5: busy drops in cycle 6, no done, results held.
        issue(2'b10, 32'd77, 32'd5);
        repeat (4) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_busy", 64'(bus.busy), 64'd0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) seen = 1'b1;
            @(negedge clk);
        end
        check("cancel_no_done", 64'(seen), 64'd0);
        check("cancel_hi", 64'(bus.hi), 64'd0);
        check("cancel_lo", 64'(bus.lo), 64'h00123400);

        // Cancel in the FIX cycle (cycle 33) also suppresses the write.
        issue(2'b00, 32'd5, 32'd5);
        repeat (32) @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        check("cancel_fix_busy", 64'(bus.busy), 64'd0);
        check("cancel_fix_done", 64'(bus.done), 64'd0);
        check("cancel_fix_lo", 64'(bus.lo), 64'h00123400);

        // Start and cancel together in IDLE: start wins.
        @(negedge clk);
        bus.cancel = 1'b1;
        issue(2'b00, 32'd7, 32'd9);
        bus.cancel = 1'b0;
        wait_done(1, cyc, bok);
        check("startwins_latency", 64'(cyc), 64'd34);
        check("startwins_lo", 64'(bus.lo), 64'd63);

        // Asynchronous reset mid-CALC.
        issue(2'b01, 32'hFFFFFFF0, 32'd3);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_done", 64'(bus.done), 64'd0);
        check("arst_hi",   64'(bus.hi),   64'd0);
        check("arst_lo",   64'(bus.lo),   64'd0);
        check("arst_dbz",  64'(bus.div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back: start in the done cycle.
        issue(2'b00, 32'd3, 32'd5);
        wait_done(1, cyc, bok);
        check("b2b_first_latency", 64'(cyc), 64'd34);
        check("b2b_first_lo", 64'(bus.lo), 64'd15);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.srcA  = 32'd50;
        bus.srcB  = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(1, cyc, bok);
        check("b2b_second_latency", 64'(cyc), 64'd34);
        check("b2b_second_busy", 64'(bok), 64'd1);
        check("b2b_second_lo", 64'(bus.lo), 64'd7);
        check("b2b_second_hi", 64'(bus.hi), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
